morty_branch_ctrl: RTL and testbench

Sequencing controller for the branch comparator in the Morty RV32 execute stage.
- Accepts one branch/jump op at a time from decode over a valid/ready handshake.
- Drives the comparator for one evaluation cycle, resolves taken/not-taken and the target, and returns a link result.
- On a taken branch, issues a held redirect to fetch, then a fixed-length flush window.

---
 rtl/morty_branch_ctrl.sv | 125 ++++++++++++
 tb/tb_morty_branch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morty_branch_ctrl.sv
// morty_branch_ctrl: sequences the branch comparator for one op, resolves direction/target, redirects fetch and flushes.
// Ports: clk_i/rst_ni clock and async active-low reset; kill_i synchronous abort;
//   in_* decode handshake and op fields; cmp_* comparator drive and take result;
//   res_* one-cycle resolution pulse with direction and link; redir_* held redirect to fetch;
//   flush_o squash window; misalign_o taken-target misalignment pulse.
// Optional: define MORTY_BRANCH_STATS_EN to add saturating stat_resolved_o/stat_taken_o/stat_misalign_o counters.
module morty_branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_W       = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            kill_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      in_kind_i,
    input  logic [2:0]      in_sel_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic [XLEN-1:0] in_drs1_i,
    input  logic [XLEN-1:0] in_drs2_i,
    output logic [2:0]      cmp_sel_o,
    output logic [XLEN-1:0] cmp_drs1_o,
    output logic [XLEN-1:0] cmp_drs2_o,
    input  logic            cmp_take_i,
    output logic            res_valid_o,
    output logic            res_taken_o,
    output logic [XLEN-1:0] res_link_o,
    output logic            redir_valid_o,
    input  logic            redir_ready_i,
    output logic [XLEN-1:0] redir_pc_o,
    output logic            flush_o,
    output logic            misalign_o
`ifdef MORTY_BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_resolved_o,
    output logic [STAT_W-1:0] stat_taken_o,
    output logic [STAT_W-1:0] stat_misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, EVAL, REDIR, FLUSH} state_t;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_t          state;
    logic [1:0]      kind;
    logic [2:0]      sel;
    logic [XLEN-1:0] pc, imm, drs1, drs2;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] target, link;
    logic            eval, taken;

    assign eval          = state == EVAL;
    // Reserved kind is folded to conditional at accept time, so only kind 0 consults the comparator.
    assign taken         = kind == 2'd0 ? cmp_take_i : 1'b1;
    assign target        = kind == 2'd2 ? (drs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0} : pc + imm;
    assign link          = pc + XLEN'(4);
    assign in_ready_o    = state == IDLE;
    assign redir_valid_o = state == REDIR;
    assign flush_o       = state == FLUSH;
    assign cmp_sel_o     = eval && kind == 2'd0 ? sel : 3'd0;
    assign cmp_drs1_o    = eval ? drs1 : '0;
    assign cmp_drs2_o    = eval ? drs2 : '0;
    assign res_valid_o   = eval & ~kill_i;
    assign res_taken_o   = res_valid_o & taken;
    assign res_link_o    = res_valid_o ? link : '0;
    assign misalign_o    = res_taken_o & target[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            kind       <= '0;
            sel        <= '0;
            pc         <= '0;
            imm        <= '0;
            drs1       <= '0;
            drs2       <= '0;
            cnt        <= '0;
            redir_pc_o <= '0;
        end else if (kill_i) begin
            state      <= IDLE;
            cnt        <= '0;
            redir_pc_o <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    state <= EVAL;
                    kind  <= in_kind_i == 2'd3 ? 2'd0 : in_kind_i;
                    sel   <= in_kind_i == 2'd3 ? 3'd0 : in_sel_i;
                    pc    <= in_pc_i;
                    imm   <= in_imm_i;
                    drs1  <= in_drs1_i;
                    drs2  <= in_drs2_i;
                end
                EVAL: begin
                    state      <= taken && !target[1] ? REDIR : IDLE;
                    redir_pc_o <= taken && !target[1] ? target : redir_pc_o;
                end
                REDIR: if (redir_ready_i) begin
                    state <= FLUSH;
                    cnt   <= CW'(FLUSH_CYCLES);
                end
                default: begin
                    state <= cnt == CW'(1) ? IDLE : FLUSH;
                    cnt   <= cnt - CW'(1);
                end
            endcase
        end
    end

`ifdef MORTY_BRANCH_STATS_EN
    // Counters ignore kill_i; a killed EVAL produces no pulse, so it is simply not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_resolved_o <= '0;
            stat_taken_o    <= '0;
            stat_misalign_o <= '0;
        end else begin
            if (res_valid_o && !(&stat_resolved_o)) stat_resolved_o <= stat_resolved_o + STAT_W'(1);
            if (res_taken_o && !(&stat_taken_o))    stat_taken_o    <= stat_taken_o + STAT_W'(1);
            if (misalign_o && !(&stat_misalign_o))  stat_misalign_o <= stat_misalign_o + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_morty_branch_ctrl.sv
// tb_morty_branch_ctrl: table-driven, hand-sequenced and random checks of morty_branch_ctrl against a reference model.
module tb_morty_branch_ctrl;
    localparam int FC = 2;

    logic        clk = 0, rst_n = 0, kill = 0, in_valid = 0, in_ready;
    logic [1:0]  in_kind = 0;
    logic [2:0]  in_sel = 0, cmp_sel;
    logic [31:0] in_pc = 0, in_imm = 0, in_drs1 = 0, in_drs2 = 0;
    logic [31:0] cmp_drs1, cmp_drs2, res_link, redir_pc;
    logic        cmp_take, res_valid, res_taken, redir_valid, redir_ready = 0, flush, misalign;
`ifdef MORTY_BRANCH_STATS_EN
    logic [15:0] stat_resolved, stat_taken, stat_misalign;
`endif

    int errors = 0, checks = 0;
    int n_res = 0, n_tak = 0, n_mis = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  sel;
        logic [31:0] pc, imm, d1, d2;
        int          delay;
        logic        taken;
        logic [31:0] link, tgt;
        logic        mis;
    } vec_t;

    always #5 clk = ~clk;

    morty_branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .STAT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .kill_i(kill),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_kind_i(in_kind), .in_sel_i(in_sel),
        .in_pc_i(in_pc), .in_imm_i(in_imm), .in_drs1_i(in_drs1), .in_drs2_i(in_drs2),
        .cmp_sel_o(cmp_sel), .cmp_drs1_o(cmp_drs1), .cmp_drs2_o(cmp_drs2), .cmp_take_i(cmp_take),
        .res_valid_o(res_valid), .res_taken_o(res_taken), .res_link_o(res_link),
        .redir_valid_o(redir_valid), .redir_ready_i(redir_ready), .redir_pc_o(redir_pc),
        .flush_o(flush), .misalign_o(misalign)
`ifdef MORTY_BRANCH_STATS_EN
        , .stat_resolved_o(stat_resolved), .stat_taken_o(stat_taken), .stat_misalign_o(stat_misalign)
`endif
    );

    function automatic logic ref_cmp(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) < $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a < b;
            3'd6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_take = ref_cmp(cmp_sel, cmp_drs1, cmp_drs2);

    function automatic vec_t ref_op(input logic [1:0] k, input logic [2:0] s, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b, input int dl);
        vec_t v;
        v.kind = k; v.sel = s; v.pc = pc; v.imm = imm; v.d1 = a; v.d2 = b; v.delay = dl;
        v.taken = (k == 2'd1 || k == 2'd2) ? 1'b1 : (k == 2'd0 ? ref_cmp(s, a, b) : 1'b0);
        v.tgt   = k == 2'd2 ? (a + imm) & 32'hFFFF_FFFE : pc + imm;
        v.link  = pc + 32'd4;
        v.mis   = v.taken && v.tgt[1];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] k, input logic [2:0] s, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; in_kind = k; in_sel = s; in_pc = pc; in_imm = imm; in_drs1 = a; in_drs2 = b;
        tick;
        in_valid = 0;
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        chk("idle_ready", {31'd0, in_ready}, 1);
        chk("idle_res_valid", {31'd0, res_valid}, 0);
        chk("idle_cmp_drs1", cmp_drs1, 0);
        issue(v.kind, v.sel, v.pc, v.imm, v.d1, v.d2);
        chk("eval_res_valid", {31'd0, res_valid}, 1);
        chk("eval_res_taken", {31'd0, res_taken}, {31'd0, v.taken});
        chk("eval_res_link", res_link, v.link);
        chk("eval_misalign", {31'd0, misalign}, {31'd0, v.mis});
        chk("eval_cmp_sel", {29'd0, cmp_sel}, v.kind == 2'd0 ? {29'd0, v.sel} : 0);
        chk("eval_cmp_drs1", cmp_drs1, v.d1);
        chk("eval_cmp_drs2", cmp_drs2, v.d2);
        chk("eval_ready", {31'd0, in_ready}, 0);
        n_res++; n_tak += int'(v.taken); n_mis += int'(v.mis);
        tick;
        if (v.taken && !v.mis) begin
            for (int d = 0; d <= v.delay; d++) begin
                chk("redir_valid", {31'd0, redir_valid}, 1);
                chk("redir_pc", redir_pc, v.tgt);
                chk("redir_no_flush", {31'd0, flush}, 0);
                redir_ready = (d == v.delay);
                tick;
            end
            redir_ready = 0;
            n = 0;
            while (flush && n < 20) begin
                chk("flush_no_ready", {31'd0, in_ready}, 0);
                n++;
                tick;
            end
            chk("flush_len", n, FC);
        end
        chk("end_ready", {31'd0, in_ready}, 1);
        chk("end_redir_valid", {31'd0, redir_valid}, 0);
        chk("end_flush", {31'd0, flush}, 0);
    endtask

    task automatic to_redir;
        issue(2'd0, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5);
        n_res++; n_tak++;
        tick;
        chk("seq_in_redir", {31'd0, redir_valid}, 1);
    endtask

    vec_t tab[8];

    initial begin
        tab[0] = '{2'd0, 3'd1, 32'h100,      32'h20, 32'd5,        32'd5,        3, 1'b1, 32'h104,      32'h120,  1'b0};
        tab[1] = '{2'd0, 3'd5, 32'h200,      32'h10, 32'hFFFFFFFF, 32'd1,        0, 1'b0, 32'h204,      32'h210,  1'b0};
        tab[2] = '{2'd0, 3'd3, 32'h200,      32'h10, 32'hFFFFFFFF, 32'd1,        1, 1'b1, 32'h204,      32'h210,  1'b0};
        tab[3] = '{2'd2, 3'd0, 32'h300,      32'h2,  32'h1001,     32'd0,        0, 1'b1, 32'h304,      32'h1002, 1'b1};
        tab[4] = '{2'd1, 3'd1, 32'hFFFFFFFC, 32'h8,  32'd7,        32'd9,        0, 1'b1, 32'h0,        32'h4,    1'b0};
        tab[5] = '{2'd3, 3'd1, 32'h400,      32'h40, 32'd3,        32'd3,        0, 1'b0, 32'h404,      32'h440,  1'b0};
        tab[6] = '{2'd0, 3'd7, 32'h500,      32'h40, 32'd3,        32'd3,        0, 1'b0, 32'h504,      32'h540,  1'b0};
        tab[7] = '{2'd0, 3'd4, 32'h600,      32'hFFFFFFF0, 32'hFFFFFFFB, 32'hFFFFFFFB, 2, 1'b1, 32'h604, 32'h5F0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 1);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_redir_valid", {31'd0, redir_valid}, 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_res_link", res_link, 0);
        rst_n = 1;
        tick;

        for (int i = 0; i < 8; i++) run_op(tab[i]);

        // kill in REDIR
        to_redir;
        kill = 1;
        tick;
        kill = 0;
        #1;
        chk("kill_redir_valid", {31'd0, redir_valid}, 0);
        chk("kill_redir_ready", {31'd0, in_ready}, 1);
        // kill in FLUSH
        to_redir;
        redir_ready = 1;
        tick;
        redir_ready = 0;
        chk("kill_flush_pre", {31'd0, flush}, 1);
        kill = 1;
        tick;
        kill = 0;
        #1;
        chk("kill_flush", {31'd0, flush}, 0);
        chk("kill_flush_ready", {31'd0, in_ready}, 1);
        // kill in EVAL suppresses the resolution pulse
        in_valid = 1; in_kind = 2'd2; in_pc = 32'h0; in_imm = 32'h2; in_drs1 = 32'h1001;
        tick;
        in_valid = 0;
        kill = 1;
        #1;
        chk("kill_eval_res", {31'd0, res_valid}, 0);
        chk("kill_eval_mis", {31'd0, misalign}, 0);
        tick;
        kill = 0;
        #1;
        chk("kill_eval_ready", {31'd0, in_ready}, 1);
        // kill with in_valid in IDLE: not accepted
        in_valid = 1; kill = 1; in_kind = 2'd1;
        tick;
        in_valid = 0; kill = 0;
        #1;
        chk("kill_idle_ready", {31'd0, in_ready}, 1);
        chk("kill_idle_res", {31'd0, res_valid}, 0);
        tick;
        chk("kill_idle_redir", {31'd0, redir_valid}, 0);
        // redir_ready outside REDIR is ignored
        redir_ready = 1;
        tick;
        redir_ready = 0;
        chk("stray_ready_flush", {31'd0, flush}, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, imm;
            a   = $urandom;
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            run_op(ref_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
                          imm, a, $urandom_range(0, 1) ? a : $urandom, $urandom_range(0, 3)));
        end

`ifdef MORTY_BRANCH_STATS_EN
        chk("stat_resolved", {16'd0, stat_resolved}, n_res);
        chk("stat_taken", {16'd0, stat_taken}, n_tak);
        chk("stat_misalign", {16'd0, stat_misalign}, n_mis);
`endif

        // async reset during REDIR
        to_redir;
        rst_n = 0;
        #1;
        chk("areset_redir_valid", {31'd0, redir_valid}, 0);
        chk("areset_ready", {31'd0, in_ready}, 1);
        chk("areset_redir_pc", redir_pc, 0);
        chk("areset_flush", {31'd0, flush}, 0);
        tick;
        rst_n = 1;
        tick;
        chk("post_reset_redir", {31'd0, redir_valid}, 0);
        chk("post_reset_flush", {31'd0, flush}, 0);
`ifdef MORTY_BRANCH_STATS_EN
        chk("stat_reset", {16'd0, stat_resolved}, 0);
`endif
        run_op(tab[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
